// File: rtl/tcp_echo_bench_role.sv
`default_nettype none
// ============================================================================
// Module  : tcp_echo_bench_role
// Brief   : Single-session TCP benchmark role; echoes or sinks each payload.
// Rev     : 1.0
// ============================================================================
module tcp_echo_bench_role #(
   parameter int          DATA_WIDTH    = 64,
   parameter logic [15:0] LISTEN_PORT   = 16'd5001,
   parameter int          MAX_PKT_BYTES = 1536,
   parameter int          FIFO_DEPTH    = (MAX_PKT_BYTES * 8 + DATA_WIDTH - 1) / DATA_WIDTH,
   parameter bit          ECHO_MODE     = 1'b1,
   parameter int          RETRY_CYCLES  = 1024
) (
   input  logic                    user_clk,
   input  logic                    user_areset,
   output logic                    m_listen_port_valid,
   input  logic                    m_listen_port_ready,
   output logic [15:0]             m_listen_port_data,
   input  logic                    s_listen_status_valid,
   output logic                    s_listen_status_ready,
   input  logic [7:0]              s_listen_status_data,
   input  logic                    s_notif_valid,
   output logic                    s_notif_ready,
   input  logic [87:0]             s_notif_data,
   output logic                    m_read_pkg_valid,
   input  logic                    m_read_pkg_ready,
   output logic [31:0]             m_read_pkg_data,
   input  logic                    s_rx_meta_valid,
   output logic                    s_rx_meta_ready,
   input  logic [15:0]             s_rx_meta_data,
   input  logic                    s_rx_data_valid,
   output logic                    s_rx_data_ready,
   input  logic [DATA_WIDTH-1:0]   s_rx_data_data,
   input  logic [DATA_WIDTH/8-1:0] s_rx_data_keep,
   input  logic                    s_rx_data_last,
   output logic                    m_tx_meta_valid,
   input  logic                    m_tx_meta_ready,
   output logic [31:0]             m_tx_meta_data,
   input  logic                    s_tx_status_valid,
   output logic                    s_tx_status_ready,
   input  logic [63:0]             s_tx_status_data,
   output logic                    m_tx_data_valid,
   input  logic                    m_tx_data_ready,
   output logic [DATA_WIDTH-1:0]   m_tx_data_data,
   output logic [DATA_WIDTH/8-1:0] m_tx_data_keep,
   output logic                    m_tx_data_last,
   output logic [63:0]             rx_bytes,
   output logic [63:0]             tx_bytes,
   output logic [31:0]             pkt_count,
   output logic [15:0]             err_count,
   output logic                    listening
);

   localparam int c_keep_w  = DATA_WIDTH / 8;
   localparam int c_ent_w   = DATA_WIDTH + c_keep_w + 1;
   localparam int c_addr_w  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_retry_w = $clog2(RETRY_CYCLES + 1);
   localparam logic [c_addr_w-1:0]  c_last_addr = c_addr_w'(FIFO_DEPTH - 1);
   localparam logic [c_retry_w-1:0] c_retry_end = c_retry_w'(RETRY_CYCLES - 1);

   typedef enum logic [3:0] {
      ST_LISTEN_REQ  = 4'd0,
      ST_LISTEN_WAIT = 4'd1,
      ST_RETRY       = 4'd2,
      ST_IDLE        = 4'd3,
      ST_READ_REQ    = 4'd4,
      ST_RX_META     = 4'd5,
      ST_RX_DATA     = 4'd6,
      ST_TX_META     = 4'd7,
      ST_TX_STATUS   = 4'd8,
      ST_TX_DATA     = 4'd9,
      ST_FLUSH       = 4'd10
   } state_t;

   state_t                 r_state;
   logic [15:0]            r_session;
   logic [15:0]            r_length;
   logic                   r_discard;
   logic [c_retry_w-1:0]   r_retry_cnt;
   logic [c_ent_w-1:0]     r_mem [FIFO_DEPTH];
   logic [c_addr_w:0]      r_wr_ptr;
   logic [c_addr_w:0]      r_rd_ptr;

   logic                   w_empty;
   logic                   w_full;
   logic [c_ent_w-1:0]     w_head;
   logic                   w_rx_fire;
   logic                   w_push;
   logic                   w_tx_fire;
   logic                   w_pop;
   logic                   w_notif_skip;
   logic                   w_unused_bits;

   // Pointer MSB toggles on each wrap so equal addresses disambiguate full/empty
   function automatic logic [c_addr_w:0] ptr_inc(input logic [c_addr_w:0] p);
      if (p[c_addr_w-1:0] == c_last_addr)
         return {~p[c_addr_w], {c_addr_w{1'b0}}};
      return p + 1'b1;
   endfunction

   function automatic logic [63:0] popcount(input logic [c_keep_w-1:0] k);
      logic [63:0] n;
      n = '0;
      for (int i = 0; i < c_keep_w; i++)
         n = n + {63'd0, k[i]};
      return n;
   endfunction

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]) &&
                    (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]);
   assign w_head  = r_mem[r_rd_ptr[c_addr_w-1:0]];

   assign s_listen_status_ready = (r_state == ST_LISTEN_WAIT);
   assign s_notif_ready         = (r_state == ST_IDLE);
   assign s_rx_meta_ready       = (r_state == ST_RX_META);
   assign s_rx_data_ready       = (r_state == ST_RX_DATA) && (r_discard || !w_full);
   assign s_tx_status_ready     = (r_state == ST_TX_STATUS);

   assign m_tx_data_valid = (r_state == ST_TX_DATA) && !w_empty;
   assign m_tx_data_data  = w_head[c_ent_w-1 -: DATA_WIDTH];
   assign m_tx_data_keep  = w_head[c_keep_w:1];
   assign m_tx_data_last  = w_head[0];

   assign w_rx_fire    = s_rx_data_valid && s_rx_data_ready;
   assign w_push       = w_rx_fire && !r_discard;
   assign w_tx_fire    = m_tx_data_valid && m_tx_data_ready;
   assign w_pop        = w_tx_fire || ((r_state == ST_FLUSH) && !w_empty);
   assign w_notif_skip = s_notif_data[80] || (s_notif_data[31:16] == 16'd0);

   assign w_unused_bits = ^{s_listen_status_data[7:1], s_notif_data[87:81],
                            s_notif_data[79:32], s_rx_meta_data, s_tx_status_data[61:0]};

   always_ff @(posedge user_clk) begin
      if (w_push)
         r_mem[r_wr_ptr[c_addr_w-1:0]] <= {s_rx_data_data, s_rx_data_keep, s_rx_data_last};
   end

   always_ff @(posedge user_clk or posedge user_areset) begin
      if (user_areset) begin
         r_state             <= ST_LISTEN_REQ;
         r_session           <= '0;
         r_length            <= '0;
         r_discard           <= 1'b0;
         r_retry_cnt         <= '0;
         r_wr_ptr            <= '0;
         r_rd_ptr            <= '0;
         m_listen_port_valid <= 1'b0;
         m_listen_port_data  <= '0;
         m_read_pkg_valid    <= 1'b0;
         m_read_pkg_data     <= '0;
         m_tx_meta_valid     <= 1'b0;
         m_tx_meta_data      <= '0;
         rx_bytes            <= '0;
         tx_bytes            <= '0;
         pkt_count           <= '0;
         err_count           <= '0;
         listening           <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_rx_fire) rx_bytes <= rx_bytes + popcount(s_rx_data_keep);
         if (w_tx_fire) tx_bytes <= tx_bytes + popcount(m_tx_data_keep);

         case (r_state)
            ST_LISTEN_REQ: begin
               if (!m_listen_port_valid) begin
                  m_listen_port_valid <= 1'b1;
                  m_listen_port_data  <= LISTEN_PORT;
               end else if (m_listen_port_ready) begin
                  m_listen_port_valid <= 1'b0;
                  r_state             <= ST_LISTEN_WAIT;
               end
            end
            ST_LISTEN_WAIT: begin
               if (s_listen_status_valid) begin
                  if (s_listen_status_data[0]) begin
                     listening <= 1'b1;
                     r_state   <= ST_IDLE;
                  end else begin
                     r_retry_cnt <= '0;
                     r_state     <= ST_RETRY;
                  end
               end
            end
            ST_RETRY: begin
               if (r_retry_cnt == c_retry_end) r_state <= ST_LISTEN_REQ;
               else                            r_retry_cnt <= r_retry_cnt + 1'b1;
            end
            ST_IDLE: begin
               if (s_notif_valid && !w_notif_skip) begin
                  r_session <= s_notif_data[15:0];
                  r_length  <= s_notif_data[31:16];
                  r_discard <= ({16'd0, s_notif_data[31:16]} > 32'(MAX_PKT_BYTES)) || !ECHO_MODE;
                  pkt_count <= pkt_count + 32'd1;
                  r_state   <= ST_READ_REQ;
               end
            end
            ST_READ_REQ: begin
               if (!m_read_pkg_valid) begin
                  m_read_pkg_valid <= 1'b1;
                  m_read_pkg_data  <= {r_length, r_session};
               end else if (m_read_pkg_ready) begin
                  m_read_pkg_valid <= 1'b0;
                  r_state          <= ST_RX_META;
               end
            end
            ST_RX_META: begin
               if (s_rx_meta_valid) r_state <= ST_RX_DATA;
            end
            ST_RX_DATA: begin
               if (w_rx_fire && s_rx_data_last) begin
                  if (!ECHO_MODE) begin
                     r_state <= ST_IDLE;
                  end else if (r_discard) begin
                     if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                     r_state <= ST_IDLE;
                  end else begin
                     r_state <= ST_TX_META;
                  end
               end
            end
            ST_TX_META: begin
               if (!m_tx_meta_valid) begin
                  m_tx_meta_valid <= 1'b1;
                  m_tx_meta_data  <= {r_length, r_session};
               end else if (m_tx_meta_ready) begin
                  m_tx_meta_valid <= 1'b0;
                  r_state         <= ST_TX_STATUS;
               end
            end
            ST_TX_STATUS: begin
               if (s_tx_status_valid) begin
                  if (s_tx_status_data[63:62] == 2'b00) begin
                     r_state <= ST_TX_DATA;
                  end else begin
                     if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                     r_state <= ST_FLUSH;
                  end
               end
            end
            ST_TX_DATA: begin
               if (w_tx_fire && m_tx_data_last) r_state <= ST_IDLE;
            end
            ST_FLUSH: begin
               if (!w_empty && w_head[0]) r_state <= ST_IDLE;
            end
            default: r_state <= ST_LISTEN_REQ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tcp_echo_bench_role.sv
`default_nettype none
// Randomized bench for tcp_echo_bench_role against a packet-level reference model.
module tb_tcp_echo_bench_role;

   localparam int DW     = 64;
   localparam int MAXB   = 1536;
   localparam int DEPTH  = 192;
   localparam int RETRY  = 1024;
   localparam int BUDGET = 5000;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } beat_t;

   logic        user_clk = 1'b0;
   logic        user_areset;
   logic        m_listen_port_valid, m_listen_port_ready;
   logic [15:0] m_listen_port_data;
   logic        s_listen_status_valid, s_listen_status_ready;
   logic [7:0]  s_listen_status_data;
   logic        s_notif_valid, s_notif_ready;
   logic [87:0] s_notif_data;
   logic        m_read_pkg_valid, m_read_pkg_ready;
   logic [31:0] m_read_pkg_data;
   logic        s_rx_meta_valid, s_rx_meta_ready;
   logic [15:0] s_rx_meta_data;
   logic        s_rx_data_valid, s_rx_data_ready, s_rx_data_last;
   logic [63:0] s_rx_data_data;
   logic [7:0]  s_rx_data_keep;
   logic        m_tx_meta_valid, m_tx_meta_ready;
   logic [31:0] m_tx_meta_data;
   logic        s_tx_status_valid, s_tx_status_ready;
   logic [63:0] s_tx_status_data;
   logic        m_tx_data_valid, m_tx_data_ready, m_tx_data_last;
   logic [63:0] m_tx_data_data;
   logic [7:0]  m_tx_data_keep;
   logic [63:0] rx_bytes, tx_bytes;
   logic [31:0] pkt_count;
   logic [15:0] err_count;
   logic        listening;

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] exp_rx = '0, exp_tx = '0;
   logic [31:0] exp_pkt = '0;
   logic [15:0] exp_err = '0;
   beat_t       exp_q[$];

   tcp_echo_bench_role #(.DATA_WIDTH(DW), .LISTEN_PORT(16'd5001), .MAX_PKT_BYTES(MAXB),
                         .ECHO_MODE(1'b1), .RETRY_CYCLES(RETRY)) dut (
      .user_clk(user_clk), .user_areset(user_areset),
      .m_listen_port_valid(m_listen_port_valid), .m_listen_port_ready(m_listen_port_ready),
      .m_listen_port_data(m_listen_port_data),
      .s_listen_status_valid(s_listen_status_valid), .s_listen_status_ready(s_listen_status_ready),
      .s_listen_status_data(s_listen_status_data),
      .s_notif_valid(s_notif_valid), .s_notif_ready(s_notif_ready), .s_notif_data(s_notif_data),
      .m_read_pkg_valid(m_read_pkg_valid), .m_read_pkg_ready(m_read_pkg_ready),
      .m_read_pkg_data(m_read_pkg_data),
      .s_rx_meta_valid(s_rx_meta_valid), .s_rx_meta_ready(s_rx_meta_ready),
      .s_rx_meta_data(s_rx_meta_data),
      .s_rx_data_valid(s_rx_data_valid), .s_rx_data_ready(s_rx_data_ready),
      .s_rx_data_data(s_rx_data_data), .s_rx_data_keep(s_rx_data_keep),
      .s_rx_data_last(s_rx_data_last),
      .m_tx_meta_valid(m_tx_meta_valid), .m_tx_meta_ready(m_tx_meta_ready),
      .m_tx_meta_data(m_tx_meta_data),
      .s_tx_status_valid(s_tx_status_valid), .s_tx_status_ready(s_tx_status_ready),
      .s_tx_status_data(s_tx_status_data),
      .m_tx_data_valid(m_tx_data_valid), .m_tx_data_ready(m_tx_data_ready),
      .m_tx_data_data(m_tx_data_data), .m_tx_data_keep(m_tx_data_keep),
      .m_tx_data_last(m_tx_data_last),
      .rx_bytes(rx_bytes), .tx_bytes(tx_bytes), .pkt_count(pkt_count),
      .err_count(err_count), .listening(listening)
   );

   always #5 user_clk = ~user_clk;
   always @(posedge user_clk) cyc <= cyc + 1;

   task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_value({tag, "_ctl"}, {m_listen_port_valid, s_listen_status_ready, s_notif_ready,
                  m_read_pkg_valid, s_rx_meta_ready, s_rx_data_ready, m_tx_meta_valid,
                  s_tx_status_ready, m_tx_data_valid, listening}, 0);
      check_value({tag, "_counters"}, {rx_bytes, tx_bytes, pkt_count, err_count}, 0);
   endtask

   task automatic check_counters(input string tag);
      check_value({tag, "_rx_bytes"}, rx_bytes, exp_rx);
      check_value({tag, "_tx_bytes"}, tx_bytes, exp_tx);
      check_value({tag, "_pkt_count"}, pkt_count, exp_pkt);
      check_value({tag, "_err_count"}, err_count, exp_err);
   endtask

   task automatic watch_quiet(input string tag, input int cycles);
      int hits = 0;
      repeat (cycles) begin
         @(negedge user_clk);
         if (m_read_pkg_valid || m_tx_meta_valid || m_tx_data_valid) hits++;
      end
      check_value(tag, hits, 0);
   endtask

   task automatic recv_listen(output int t);
      int n = 0;
      while (!m_listen_port_valid && n < BUDGET) begin @(negedge user_clk); n++; end
      check_value("listen_req_seen", n < BUDGET, 1);
      check_value("listen_port", m_listen_port_data, 16'd5001);
      t = cyc;
      m_listen_port_ready = 1'b1;
      @(negedge user_clk);
      m_listen_port_ready = 1'b0;
   endtask

   task automatic send_listen_status(input logic [7:0] d);
      int n = 0;
      s_listen_status_valid = 1'b1;
      s_listen_status_data  = d;
      while (!s_listen_status_ready && n < BUDGET) begin @(negedge user_clk); n++; end
      check_value("listen_status_taken", n < BUDGET, 1);
      @(negedge user_clk);
      s_listen_status_valid = 1'b0;
   endtask

   task automatic send_notif(input logic closed, input logic [15:0] len, input logic [15:0] sess);
      int n = 0;
      s_notif_valid = 1'b1;
      s_notif_data  = {7'd0, closed, 16'($urandom), 32'($urandom), len, sess};
      while (!s_notif_ready && n < BUDGET) begin @(negedge user_clk); n++; end
      check_value("notif_taken", n < BUDGET, 1);
      @(negedge user_clk);
      s_notif_valid = 1'b0;
   endtask

   task automatic recv_read_pkg(input logic [31:0] exp);
      int n = 0;
      while (!m_read_pkg_valid && n < BUDGET) begin @(negedge user_clk); n++; end
      check_value("read_pkg_seen", n < BUDGET, 1);
      repeat ($urandom_range(0, 3)) begin
         @(negedge user_clk);
         check_value("read_pkg_hold", {m_read_pkg_valid, m_read_pkg_data}, {1'b1, exp});
      end
      check_value("read_pkg_data", m_read_pkg_data, exp);
      m_read_pkg_ready = 1'b1;
      @(negedge user_clk);
      m_read_pkg_ready = 1'b0;
   endtask

   task automatic recv_tx_meta(input logic [31:0] exp);
      int n = 0;
      while (!m_tx_meta_valid && n < BUDGET) begin @(negedge user_clk); n++; end
      check_value("tx_meta_seen", n < BUDGET, 1);
      repeat ($urandom_range(0, 3)) begin
         @(negedge user_clk);
         check_value("tx_meta_hold", {m_tx_meta_valid, m_tx_meta_data}, {1'b1, exp});
      end
      check_value("tx_meta_data", m_tx_meta_data, exp);
      m_tx_meta_ready = 1'b1;
      @(negedge user_clk);
      m_tx_meta_ready = 1'b0;
   endtask

   task automatic send_rx_meta();
      int n = 0;
      s_rx_meta_valid = 1'b1;
      s_rx_meta_data  = 16'($urandom);
      while (!s_rx_meta_ready && n < BUDGET) begin @(negedge user_clk); n++; end
      check_value("rx_meta_taken", n < BUDGET, 1);
      @(negedge user_clk);
      s_rx_meta_valid = 1'b0;
   endtask

   task automatic send_tx_status(input logic [1:0] e);
      int n = 0;
      s_tx_status_valid = 1'b1;
      s_tx_status_data  = {e, $urandom, 30'($urandom)};
      while (!s_tx_status_ready && n < BUDGET) begin @(negedge user_clk); n++; end
      check_value("tx_status_taken", n < BUDGET, 1);
      @(negedge user_clk);
      s_tx_status_valid = 1'b0;
   endtask

   // Payload of len bytes: full 8-byte beats, remainder in the low keep bits of the last beat
   task automatic send_rx(input int len, input bit keep_copy);
      int nb = (len + 7) / 8;
      int rem = len % 8;
      beat_t b;
      for (int i = 0; i < nb; i++) begin
         int n = 0;
         if ($urandom_range(0, 3) == 0) begin s_rx_data_valid = 1'b0; @(negedge user_clk); end
         b.d = {$urandom, $urandom};
         b.l = (i == nb - 1);
         b.k = (b.l && rem != 0) ? (8'hFF >> (8 - rem)) : 8'hFF;
         s_rx_data_valid = 1'b1;
         s_rx_data_data  = b.d;
         s_rx_data_keep  = b.k;
         s_rx_data_last  = b.l;
         while (!s_rx_data_ready && n < BUDGET) begin @(negedge user_clk); n++; end
         if (n >= BUDGET) check_value("rx_beat_taken", n, 0);
         @(negedge user_clk);
         if (keep_copy) exp_q.push_back(b);
      end
      s_rx_data_valid = 1'b0;
      s_rx_data_last  = 1'b0;
   endtask

   task automatic recv_tx(input bit toggle);
      int  n = 0;
      bit  ph = 1'b0;
      bit  done = 1'b0;
      while (!done && n < BUDGET) begin
         m_tx_data_ready = toggle ? ph : 1'b1;
         ph = ~ph;
         if (m_tx_data_valid && m_tx_data_ready) begin
            if (exp_q.size() == 0) begin
               check_value("tx_extra_beat", exp_q.size(), 1);
               done = 1'b1;
            end else begin
               beat_t e = exp_q.pop_front();
               check_value("tx_beat", {m_tx_data_data, m_tx_data_keep, m_tx_data_last}, e);
               done = e.l;
            end
         end
         @(negedge user_clk);
         n++;
      end
      m_tx_data_ready = 1'b0;
      check_value("tx_done_in_time", n < BUDGET, 1);
      check_value("tx_beats_left", exp_q.size(), 0);
   endtask

   task automatic do_packet(input logic [15:0] sess, input logic [15:0] len,
                            input logic [1:0] txerr, input bit toggle);
      bit over = (int'(len) > MAXB);
      exp_q.delete();
      send_notif(1'b0, len, sess);
      recv_read_pkg({len, sess});
      send_rx_meta();
      send_rx(int'(len), !over);
      exp_rx  += 64'(len);
      exp_pkt += 1;
      if (over) begin
         if (exp_err != 16'hFFFF) exp_err += 1;
         watch_quiet("oversize_no_tx", 40);
         check_value("oversize_back_idle", s_notif_ready, 1);
      end else begin
         recv_tx_meta({len, sess});
         send_tx_status(txerr);
         if (txerr != 2'b00) begin
            if (exp_err != 16'hFFFF) exp_err += 1;
            watch_quiet("flush_no_tx", 2 * int'(len) / 8 + 20);
            check_value("flush_back_idle", s_notif_ready, 1);
         end else begin
            recv_tx(toggle);
            exp_tx += 64'(len);
         end
      end
      check_counters("pkt");
   endtask

   initial begin
      int t[3];
      int hits;
      int acc;
      int lowrun;
      int n;
      user_areset = 1'b1;
      m_listen_port_ready = 0; s_listen_status_valid = 0; s_listen_status_data = 0;
      s_notif_valid = 0; s_notif_data = 0; m_read_pkg_ready = 0;
      s_rx_meta_valid = 0; s_rx_meta_data = 0;
      s_rx_data_valid = 0; s_rx_data_data = 0; s_rx_data_keep = 0; s_rx_data_last = 0;
      m_tx_meta_ready = 0; s_tx_status_valid = 0; s_tx_status_data = 0; m_tx_data_ready = 0;
      repeat (3) @(negedge user_clk);
      check_reset_outputs("reset");
      user_areset = 1'b0;

      // two failed listens then success
      for (int i = 0; i < 3; i++) begin
         recv_listen(t[i]);
         check_value("listening_before_ok", listening, 0);
         send_listen_status(i == 2 ? 8'h01 : 8'h00);
      end
      check_value("listening_after_ok", listening, 1);
      check_value("listen_spacing_1", (t[1] - t[0]) >= RETRY, 1);
      check_value("listen_spacing_2", (t[2] - t[1]) >= RETRY, 1);
      hits = 0;
      repeat (RETRY + 50) begin @(negedge user_clk); if (m_listen_port_valid) hits++; end
      check_value("no_fourth_listen", hits, 0);

      do_packet(16'h0007, 16'd20, 2'b00, 1'b0);
      check_value("first_rx_bytes", rx_bytes, 64'd20);

      // closed and zero-length notifications are swallowed
      send_notif(1'b1, 16'd100, 16'h0033);
      send_notif(1'b0, 16'd0, 16'h0034);
      watch_quiet("filtered_no_read", 20);
      check_counters("filtered");

      do_packet(16'h0100, 16'(MAXB), 2'b00, 1'b1);
      do_packet(16'h0200, 16'd2000, 2'b00, 1'b0);
      do_packet(16'h0300, 16'd300, 2'b01, 1'b0);
      do_packet(16'h0301, 16'd77, 2'b00, 1'b1);
      for (int i = 0; i < 6; i++)
         do_packet(16'($urandom), 16'($urandom_range(1, MAXB)), 2'b00, 1'($urandom));

      // overlong rx burst fills the buffer, then reset lands mid-RX_DATA
      send_notif(1'b0, 16'd8, 16'h0055);
      recv_read_pkg({16'd8, 16'h0055});
      send_rx_meta();
      acc = 0; lowrun = 0; n = 0;
      s_rx_data_valid = 1'b1; s_rx_data_keep = 8'hFF; s_rx_data_last = 1'b0;
      s_rx_data_data = {$urandom, $urandom};
      while (lowrun < 30 && n < 1000) begin
         if (s_rx_data_ready) begin acc++; lowrun = 0; end else lowrun++;
         @(negedge user_clk);
         n++;
         if (lowrun == 0) s_rx_data_data = {$urandom, $urandom};
      end
      check_value("fifo_fill_beats", acc, DEPTH);
      check_value("rx_ready_when_full", s_rx_data_ready, 0);
      user_areset = 1'b1;
      @(negedge user_clk);
      check_reset_outputs("mid_rx_reset");
      s_rx_data_valid = 1'b0;
      @(negedge user_clk);
      user_areset = 1'b0;
      exp_rx = '0; exp_tx = '0; exp_pkt = '0; exp_err = '0;
      hits = 0;
      repeat (5) begin @(negedge user_clk); if (m_tx_data_valid) hits++; end
      check_value("no_tx_after_reset", hits, 0);
      recv_listen(t[0]);
      send_listen_status(8'h01);
      check_value("relisten_ok", listening, 1);
      do_packet(16'h0777, 16'd45, 2'b00, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
